// File: rtl/spi_lcd_tx_ctrl.sv
// SPI transmit controller for LCD panels: a write FIFO of {cs, dc, data} words feeding a
// single-word SPI shifter with per-word latched mode, bit order and clock divider.
module spi_lcd_tx_ctrl #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NCS   = 2,
    parameter int unsigned DIVW  = 8,
    localparam int unsigned LW   = $clog2(DEPTH) + 1,
    localparam int unsigned CW   = $clog2(NCS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DIVW-1:0] cfg_div,
    input  logic            cfg_cpol,
    input  logic            cfg_cpha,
    input  logic            cfg_lsb_first,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [DW-1:0]   wr_data,
    input  logic            wr_dc,
    input  logic [CW-1:0]   wr_cs,
    output logic            spi_sclk,
    output logic            spi_mosi,
    output logic            spi_dc,
    output logic [NCS-1:0]  spi_csn,
    output logic            busy,
    output logic [LW-1:0]   level,
    output logic            ovf,
    input  logic [LW-1:0]   irq_thresh,
    input  logic            irq_en,
    input  logic            irq_clr,
    output logic            irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = CW + 1 + DW;
    localparam int unsigned EW = $clog2(2 * DW) + 1;
    localparam logic [EW-1:0] LastEdge = EW'(2 * DW - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_t;

    logic [FW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic            full, empty, push, drop, pop, load;
    logic [FW-1:0]   head;

    state_t          state_q, state_d;
    logic [DIVW-1:0] div_cnt_q, div_cnt_d, div_q;
    logic [EW-1:0]   edge_q, edge_d;
    logic [DW-1:0]   sh_q, sh_d;
    logic            sclk_q, sclk_d, gap_q, gap_d;
    logic            dc_q, cpol_q, cpha_q, lsb_q;
    logic [CW-1:0]   cs_q;
    logic            tick, adv;
    logic            ovf_q, flag_q, flag_d, irq_q, thresh_evt;

    assign full     = (cnt_q == LW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign wr_ready = ~full;
    assign push     = wr_valid & ~full;
    assign drop     = wr_valid & full;
    assign head     = mem[rd_ptr_q];
    assign level    = cnt_q;
    assign pop      = load;

    // FIFO storage, no reset needed on the array
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {wr_cs, wr_dc, wr_data};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Occupancy next-state; simultaneous push and pop cancel
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    assign tick = (div_cnt_q == div_q);
    // Edge k = edge_q + 1; cpha=0 advances on even k, cpha=1 on odd k except the first
    assign adv  = cpha_q ? (!edge_q[0] && (edge_q != '0)) : edge_q[0];

    // FSM and shifter next-state
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        edge_d    = edge_q;
        sh_d      = sh_q;
        sclk_d    = sclk_q;
        gap_d     = gap_q;
        load      = 1'b0;
        case (state_q)
            StIdle: begin
                // After a word, hold IDLE for one half-period before the next load
                if (gap_q) begin
                    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
                    if (tick) gap_d = 1'b0;
                end
                if (en && !empty && (!gap_q || tick)) begin
                    load    = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
                if (tick) begin
                    state_d = StShift;
                    edge_d  = '0;
                end
            end
            StShift: begin
                div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    if (adv) sh_d = lsb_q ? {1'b1, sh_q[DW-1:1]} : {sh_q[DW-2:0], 1'b1};
                    if (edge_q == LastEdge) state_d = StHold;
                end
            end
            StHold: begin
                div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
                if (tick) begin
                    if (en && !empty && (head[FW-1 -: CW] == cs_q)) begin
                        load    = 1'b1;
                        state_d = StSetup;
                    end else begin
                        state_d = StIdle;
                        gap_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            div_cnt_d = '0;
            gap_d     = 1'b0;
            sh_d      = head[DW-1:0];
            sclk_d    = cfg_cpol;
        end
    end

    // FSM, shifter and per-word latched configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            edge_q    <= '0;
            sh_q      <= '0;
            sclk_q    <= 1'b0;
            gap_q     <= 1'b0;
            div_q     <= '0;
            dc_q      <= 1'b1;
            cs_q      <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            edge_q    <= edge_d;
            sh_q      <= sh_d;
            sclk_q    <= sclk_d;
            gap_q     <= gap_d;
            if (load) begin
                div_q  <= cfg_div;
                dc_q   <= head[DW];
                cs_q   <= head[FW-1 -: CW];
                cpol_q <= cfg_cpol;
                cpha_q <= cfg_cpha;
                lsb_q  <= cfg_lsb_first;
            end
        end
    end

    assign busy     = (state_q != StIdle);
    assign spi_mosi = busy ? (lsb_q ? sh_q[0] : sh_q[DW-1]) : 1'b1;
    assign spi_dc   = busy ? dc_q : 1'b1;
    // Idle clock follows the live polarity input; forced low while reset is held
    assign spi_sclk = rst ? 1'b0 : (busy ? sclk_q : cfg_cpol);

    // One-cold chip select for the latched target while a word is in flight
    always_comb begin
        spi_csn = '1;
        for (int unsigned i = 0; i < NCS; i++) begin
            if (busy && (cs_q == CW'(i))) spi_csn[i] = 1'b0;
        end
    end

    assign thresh_evt = (cnt_q > irq_thresh) && (cnt_d <= irq_thresh);

    // Interrupt flag next-state; a set event wins over a clear
    always_comb begin
        flag_d = flag_q;
        if (drop || thresh_evt) flag_d = 1'b1;
        else if (irq_clr)       flag_d = 1'b0;
    end

    // Sticky overflow, interrupt flag and registered interrupt output
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            flag_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (drop)         ovf_q <= 1'b1;
            else if (irq_clr) ovf_q <= 1'b0;
            flag_q <= flag_d;
            irq_q  <= flag_d & irq_en;
        end
    end

    assign ovf = ovf_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_spi_lcd_tx_ctrl.sv
// Self-checking bench for spi_lcd_tx_ctrl: directed scenarios plus randomized batches,
// with a bus monitor that decodes SPI words and compares them to the written stream.
module tb_spi_lcd_tx_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int NCS   = 2;
    localparam int DIVW  = 8;
    localparam int LW    = 5;
    localparam int CW    = 1;

    logic            clk = 1'b0;
    logic            rst, en;
    logic [DIVW-1:0] cfg_div;
    logic            cfg_cpol, cfg_cpha, cfg_lsb_first;
    logic            wr_valid, wr_ready;
    logic [DW-1:0]   wr_data;
    logic            wr_dc;
    logic [CW-1:0]   wr_cs;
    logic            spi_sclk, spi_mosi, spi_dc;
    logic [NCS-1:0]  spi_csn;
    logic            busy, ovf, irq, irq_en, irq_clr;
    logic [LW-1:0]   level, irq_thresh;

    spi_lcd_tx_ctrl #(.DW(DW), .DEPTH(DEPTH), .NCS(NCS), .DIVW(DIVW)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol),
        .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_data(wr_data), .wr_dc(wr_dc), .wr_cs(wr_cs),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_dc(spi_dc), .spi_csn(spi_csn),
        .busy(busy), .level(level), .ovf(ovf), .irq_thresh(irq_thresh), .irq_en(irq_en),
        .irq_clr(irq_clr), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] cs;
        logic          dc;
        logic [DW-1:0] data;
    } word_t;

    int    total = 0;
    int    bad   = 0;
    word_t exp_q[$];
    word_t rx_q[$];

    // Bus monitor state
    int            mon_bits   = 0;
    int            mon_dc_err = 0;
    int            mon_cs_err = 0;
    int            mon_zeros;
    logic [DW-1:0] mon_data = '0;
    logic          mon_dc   = 1'b1;
    logic [CW-1:0] mon_cs   = '0;
    logic [CW-1:0] mon_cs_now;
    logic          sclk_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Decode bits on the sampling edge of the configured mode while any CS is low
    initial forever begin
        @(negedge clk);
        if (spi_csn === '1) begin
            mon_bits = 0;
        end else begin
            mon_zeros  = 0;
            mon_cs_now = '0;
            for (int i = 0; i < NCS; i++) begin
                if (spi_csn[i] === 1'b0) begin
                    mon_zeros++;
                    mon_cs_now = CW'(i);
                end
            end
            if (mon_zeros != 1) mon_cs_err++;
            if (spi_sclk !== sclk_prev && spi_sclk === (cfg_cpol == cfg_cpha)) begin
                if (mon_bits == 0) begin
                    mon_dc = spi_dc;
                    mon_cs = mon_cs_now;
                end else begin
                    if (spi_dc !== mon_dc) mon_dc_err++;
                    if (mon_cs_now !== mon_cs) mon_cs_err++;
                end
                mon_data = cfg_lsb_first ? {spi_mosi, mon_data[DW-1:1]}
                                         : {mon_data[DW-2:0], spi_mosi};
                mon_bits++;
                if (mon_bits == DW) begin
                    rx_q.push_back({mon_cs, mon_dc, mon_data});
                    mon_bits = 0;
                end
            end
        end
        sclk_prev = spi_sclk;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [CW-1:0] cs, input logic dc, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_cs    = cs;
        wr_dc    = dc;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
        exp_q.push_back({cs, dc, d});
    endtask

    task automatic count_run(input logic [NCS-1:0] pat, output int n);
        n = 0;
        while (spi_csn === pat && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy !== 1'b0 || level !== '0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < 5000), 64'd1);
        cyc(4);
    endtask

    task automatic cmp_rx(input string tag);
        check({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check({tag, "_word"}, 64'(rx_q[i]), 64'(exp_q[i]));
        check({tag, "_dc_stable"}, 64'(mon_dc_err), 64'd0);
        check({tag, "_cs_onecold"}, 64'(mon_cs_err), 64'd0);
        rx_q.delete();
        exp_q.delete();
        mon_dc_err = 0;
        mon_cs_err = 0;
    endtask

    initial begin
        int   n, g, dcbad, nw, plev, pirq;
        logic found;

        rst = 1'b1; en = 1'b0; cfg_div = '0; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        cfg_lsb_first = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_dc = 1'b0; wr_cs = '0;
        irq_thresh = '0; irq_en = 1'b0; irq_clr = 1'b0;
        cyc(3);
        check("rst_csn", 64'(spi_csn), 64'h3);
        check("rst_mosi", 64'(spi_mosi), 64'd1);
        check("rst_dc", 64'(spi_dc), 64'd1);
        check("rst_sclk", 64'(spi_sclk), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_ready", 64'(wr_ready), 64'd1);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        rst = 1'b0;
        cyc(2);

        // Mode 0, div 1, single command word to CS1
        cfg_div = 8'd1; en = 1'b1;
        wr_valid = 1'b1; wr_data = 8'hA5; wr_dc = 1'b0; wr_cs = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        exp_q.push_back({1'b1, 1'b0, 8'hA5});
        check("m0_n1_csn", 64'(spi_csn), 64'h3);
        @(negedge clk);
        check("m0_n2_csn", 64'(spi_csn), 64'h1);
        check("m0_busy", 64'(busy), 64'd1);
        n = 0; dcbad = 0;
        while (spi_csn === 2'b01 && n < 200) begin
            if (spi_dc !== 1'b0) dcbad++;
            @(negedge clk);
            n++;
        end
        check("m0_csn_len", 64'(n), 64'd36);
        check("m0_dc_low", 64'(dcbad), 64'd0);
        wait_idle("m0_idle");
        cmp_rx("m0");

        // Mode 3, LSB first, two words to CS0 back to back
        en = 1'b0; cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_lsb_first = 1'b1; cfg_div = 8'd0;
        put(1'b0, 1'b1, 8'h81);
        put(1'b0, 1'b1, 8'h3C);
        en = 1'b1;
        count_run(2'b11, n);
        count_run(2'b10, n);
        check("m3_csn_len", 64'(n), 64'd36);
        wait_idle("m3_idle");
        cmp_rx("m3");

        // CS switch forces a deassertion gap of at least one half-period
        en = 1'b0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_div = 8'd2;
        put(1'b0, 1'b0, 8'h11);
        put(1'b1, 1'b1, 8'h22);
        en = 1'b1;
        count_run(2'b11, n);
        count_run(2'b10, n);
        check("sw_cs0_len", 64'(n), 64'd54);
        count_run(2'b11, g);
        check("sw_gap_min", 64'(g >= 3), 64'd1);
        check("sw_cs1_low", 64'(spi_csn), 64'h1);
        wait_idle("sw_idle");
        cmp_rx("sw");

        // Overflow with en=0
        rst = 1'b1; cyc(1); rst = 1'b0;
        en = 1'b0; irq_en = 1'b1; irq_thresh = '0;
        cfg_cpol = 1'($urandom); cfg_cpha = 1'($urandom); cfg_lsb_first = 1'($urandom);
        cfg_div = DIVW'($urandom_range(0, 1));
        for (int i = 0; i <= DEPTH; i++) begin
            if (i == DEPTH) begin
                check("of_ready", 64'(wr_ready), 64'd0);
                check("of_level", 64'(level), 64'(DEPTH));
                check("of_ovf_pre", 64'(ovf), 64'd0);
            end
            wr_valid = 1'b1;
            wr_data  = DW'($urandom);
            wr_dc    = 1'($urandom);
            wr_cs    = CW'($urandom_range(0, NCS - 1));
            if (i < DEPTH) exp_q.push_back({wr_cs, wr_dc, wr_data});
            @(negedge clk);
        end
        wr_valid = 1'b0;
        check("of_ovf", 64'(ovf), 64'd1);
        check("of_irq", 64'(irq), 64'd1);
        check("of_level_hold", 64'(level), 64'(DEPTH));
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("clr_irq", 64'(irq), 64'd0);
        check("clr_ovf", 64'(ovf), 64'd0);
        irq_en = 1'b0; en = 1'b1;
        wait_idle("of_drain");
        cmp_rx("of");

        // Threshold interrupt on 3->2, then reset mid-word
        rst = 1'b1; cyc(1); rst = 1'b0;
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_div = 8'd0;
        irq_thresh = LW'(2); irq_en = 1'b1; en = 1'b0;
        for (int i = 0; i < 4; i++) put(1'b0, 1'b1, DW'($urandom));
        check("th_irq_pre", 64'(irq), 64'd0);
        en = 1'b1;
        found = 1'b0; plev = int'(level); pirq = int'(irq); n = 0;
        while (!found && n < 500) begin
            @(negedge clk);
            n++;
            if (level === LW'(2) && plev == 3) found = 1'b1;
            else begin
                plev = int'(level);
                pirq = int'(irq);
            end
        end
        check("th_seen", 64'(found), 64'd1);
        check("th_irq_rise", 64'(irq), 64'd1);
        check("th_irq_before", 64'(pirq), 64'd0);
        n = 0;
        while (mon_bits != 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ab_bit4", 64'(n < 200), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("ab_csn", 64'(spi_csn), 64'h3);
        check("ab_level", 64'(level), 64'd0);
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_irq", 64'(irq), 64'd0);
        rst = 1'b0;
        cyc(3);
        check("ab_level_after", 64'(level), 64'd0);
        check("ab_csn_after", 64'(spi_csn), 64'h3);
        rx_q.delete(); exp_q.delete(); mon_dc_err = 0; mon_cs_err = 0;

        // Randomized batches; divider changes mid-stream must not corrupt words
        irq_en = 1'b0;
        for (int b = 0; b < 6; b++) begin
            cfg_cpol = 1'($urandom); cfg_cpha = 1'($urandom); cfg_lsb_first = 1'($urandom);
            cfg_div = DIVW'($urandom_range(0, 3));
            en = 1'b1;
            nw = $urandom_range(1, 8);
            for (int k = 0; k < nw; k++) begin
                put(CW'($urandom_range(0, NCS - 1)), 1'($urandom), DW'($urandom));
                cfg_div = DIVW'($urandom_range(0, 3));
                cyc($urandom_range(0, 25));
            end
            wait_idle("rnd_idle");
            cmp_rx("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
